// File: rtl/hci_core_wrr_arbiter_ctrl.sv
// Weighted round-robin arbitration controller for a shared HCI/TCDM initiator port.
// Picks one of NB_REQ requesters per cycle (zero-latency select/grant), holds the
// winner stable while the shared port stalls, spends per-requester credits to give
// weighted burst shares, and routes the fixed-latency-1 response valid back.
// Optional build macro: HCI_ARB_STARVE_WATCHDOG_EN adds per-requester wait
// counters that promote a requester once it has waited STARVE_TH cycles.
module hci_core_wrr_arbiter_ctrl #(
  parameter int NB_REQ    = 4,
  parameter int WW        = 4,
  parameter int STARVE_TH = 16,
  parameter int IDXW      = $clog2(NB_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [NB_REQ*WW-1:0] cfg_weight_i,
  input  logic [NB_REQ-1:0]    req_i,
  output logic [NB_REQ-1:0]    gnt_o,
  output logic                 out_req_o,
  input  logic                 out_gnt_i,
  output logic [IDXW-1:0]      sel_o,
  input  logic                 out_r_valid_i,
  output logic [NB_REQ-1:0]    r_valid_o,
  output logic [NB_REQ-1:0]    starve_o
);

  localparam int CNT_W = $clog2(STARVE_TH + 1);

  // State
  logic [WW-1:0]   credit_q [NB_REQ];
  logic [IDXW-1:0] rr_ptr_q;
  logic [IDXW-1:0] winner_q;
  logic            lock_q;
  logic            lock_starve_q;
  logic            hs_q;

  // Next-state / combinational
  logic [WW-1:0]     credit_d    [NB_REQ];
  logic [WW-1:0]     weight_eff  [NB_REQ];
  logic [WW-1:0]     credit_view [NB_REQ];
  logic [NB_REQ-1:0] credit_nz;
  logic [NB_REQ-1:0] elig;
  logic              reload;
  logic [IDXW-1:0]   rr_win;
  logic              rr_found;
  logic [IDXW-1:0]   sel;
  logic              lock_hold;
  logic              lock_d;
  logic              hs;
  logic              starve_any;
  logic [IDXW-1:0]   starve_idx;
  logic              starve_pick;
  logic              win_is_starve;
  logic [WW-1:0]     win_credit_next;
  logic [IDXW-1:0]   rr_ptr_d;

  // Per-requester weight (0 counts as 1), credit status and the credit view used
  // this cycle (weights when every requesting port has run out of credit).
  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_credit_view
    assign weight_eff[gi]  = (cfg_weight_i[gi*WW +: WW] == '0) ? WW'(1)
                                                               : cfg_weight_i[gi*WW +: WW];
    assign credit_nz[gi]   = (credit_q[gi] != '0);
    assign credit_view[gi] = reload ? weight_eff[gi] : credit_q[gi];
  end

  assign reload = (req_i != '0) && ((req_i & credit_nz) == '0);
  assign elig   = reload ? req_i : (req_i & credit_nz);

  // Cyclic search for the first eligible requester at or after rr_ptr; walking
  // offsets downward lets the smallest offset overwrite the result last.
  always_comb begin
    int idx;
    rr_found = 1'b0;
    rr_win   = '0;
    idx      = 0;
    for (int off = NB_REQ - 1; off >= 0; off--) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      if (elig[idx]) begin
        rr_found = 1'b1;
        rr_win   = IDXW'(idx);
      end
    end
  end

`ifdef HCI_ARB_STARVE_WATCHDOG_EN
  logic [CNT_W-1:0] wait_cnt_q [NB_REQ];

  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_watchdog
    // Count cycles a requester waits without grant; saturate at the threshold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wait_cnt_q[gi] <= '0;
      end else if (clear_i) begin
        wait_cnt_q[gi] <= '0;
      end else if (!req_i[gi] || gnt_o[gi]) begin
        wait_cnt_q[gi] <= '0;
      end else if (wait_cnt_q[gi] != CNT_W'(STARVE_TH)) begin
        wait_cnt_q[gi] <= wait_cnt_q[gi] + 1'b1;
      end
    end
    assign starve_o[gi] = (wait_cnt_q[gi] == CNT_W'(STARVE_TH));
  end

  // Lowest-index starving requester is the promoted candidate.
  always_comb begin
    starve_idx = '0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      if (starve_o[k]) starve_idx = IDXW'(k);
    end
  end

  assign starve_any = |starve_o;
`else
  logic unused_starve_th;
  assign unused_starve_th = ^CNT_W'(STARVE_TH);
  assign starve_o   = '0;
  assign starve_any = 1'b0;
  assign starve_idx = '0;
`endif

  // A lock only holds while its owner still requests; if the owner drops req the
  // lock is ignored so no grant is ever steered to an idle requester.
  assign lock_hold   = lock_q && req_i[winner_q];
  assign starve_pick = !lock_hold && starve_any;

  // Winner priority: held lock, then watchdog promotion, then weighted round-robin.
  always_comb begin
    sel = '0;
    if (lock_hold)        sel = winner_q;
    else if (starve_pick) sel = starve_idx;
    else if (rr_found)    sel = rr_win;
  end

  assign out_req_o = |req_i;
  assign hs        = out_req_o & out_gnt_i;
  assign sel_o     = sel;
  assign lock_d    = out_req_o & ~out_gnt_i;

  // Grant and response routing are one-hot decodes of the current/previous winner.
  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_route
    assign gnt_o[gi]     = hs && (sel == IDXW'(gi));
    assign r_valid_o[gi] = out_r_valid_i && hs_q && (winner_q == IDXW'(gi));
  end

  // Credit after this handshake for the winner; never wraps below zero.
  assign win_is_starve   = lock_hold ? lock_starve_q : starve_pick;
  assign win_credit_next = (credit_view[sel] != '0) ? credit_view[sel] - WW'(1) : '0;

  // Burst continues on the winner while it keeps credit; promoted winners leave
  // the pointer where it was.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!win_is_starve) begin
      if (win_credit_next != '0)         rr_ptr_d = sel;
      else if (sel == IDXW'(NB_REQ - 1)) rr_ptr_d = '0;
      else                               rr_ptr_d = sel + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_credit
    assign credit_d[gi] = (sel == IDXW'(gi)) ? win_credit_next : credit_view[gi];

    // Credits only move on a handshake (reload plus winner decrement together).
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        credit_q[gi] <= '0;
      end else if (clear_i) begin
        credit_q[gi] <= '0;
      end else if (hs) begin
        credit_q[gi] <= credit_d[gi];
      end
    end
  end

  // Arbitration state: pointer, lock, and the winner/handshake pipeline for responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q      <= '0;
      winner_q      <= '0;
      lock_q        <= 1'b0;
      lock_starve_q <= 1'b0;
      hs_q          <= 1'b0;
    end else if (clear_i) begin
      rr_ptr_q      <= '0;
      winner_q      <= '0;
      lock_q        <= 1'b0;
      lock_starve_q <= 1'b0;
      hs_q          <= 1'b0;
    end else begin
      winner_q      <= sel;
      hs_q          <= hs;
      lock_q        <= lock_d;
      lock_starve_q <= win_is_starve;
      if (hs) rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_hci_core_wrr_arbiter_ctrl.sv
// Testbench for hci_core_wrr_arbiter_ctrl: table of per-cycle vectors with
// expected select/grant/starve, and a scoreboard queue for routed r_valid.
module tb_hci_core_wrr_arbiter_ctrl;

  localparam int NB = 4;
  localparam int W  = 4;
  localparam int TH = 4;
`ifdef HCI_ARB_STARVE_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic [NB*W-1:0] cfg_weight_i;
  logic [NB-1:0] req_i;
  logic [NB-1:0] gnt_o;
  logic          out_req_o;
  logic          out_gnt_i;
  logic [1:0]    sel_o;
  logic          out_r_valid_i;
  logic [NB-1:0] r_valid_o;
  logic [NB-1:0] starve_o;

  hci_core_wrr_arbiter_ctrl #(.NB_REQ(NB), .WW(W), .STARVE_TH(TH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .cfg_weight_i  (cfg_weight_i),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .out_req_o     (out_req_o),
    .out_gnt_i     (out_gnt_i),
    .sel_o         (sel_o),
    .out_r_valid_i (out_r_valid_i),
    .r_valid_o     (r_valid_o),
    .starve_o      (starve_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit        clr;
    bit        rst;   // pull rst_ni low late in this cycle
    bit [3:0]  req;
    bit        gnt;
    bit        rv;
    bit [15:0] w;
    bit [1:0]  sel;
    bit [3:0]  g;
    bit [3:0]  st;    // expected starve_o in the watchdog build
  } vec_t;

  vec_t     tbl[$];
  bit [3:0] sb[$];
  int       n_vec = 0;
  int       n_chk = 0;
  int       miscompares = 0;

  task automatic add(input bit clr, input bit rst, input bit [3:0] req, input bit gnt,
                     input bit rv, input bit [15:0] w, input bit [1:0] sel,
                     input bit [3:0] g, input bit [3:0] st);
    vec_t v;
    v.clr = clr; v.rst = rst; v.req = req; v.gnt = gnt; v.rv = rv;
    v.w = w; v.sel = sel; v.g = g; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", nm, n_vec, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bit [3:0] prev;
    bit [3:0] exp_rv;
    clear_i       = v.clr;
    req_i         = v.req;
    out_gnt_i     = v.gnt;
    out_r_valid_i = v.rv;
    cfg_weight_i  = v.w;
    @(negedge clk_i);
    n_vec++;
    prev   = (sb.size() > 0) ? sb.pop_front() : 4'h0;
    exp_rv = v.rv ? prev : 4'h0;
    $display("vec %0d clr=%0b req=%b gnt_i=%0b sel=%0d gnt=%b r_valid=%b starve=%b",
             n_vec, v.clr, v.req, v.gnt, sel_o, gnt_o, r_valid_o, starve_o);
    chk("sel_o", 32'(sel_o), 32'(v.sel));
    chk("gnt_o", 32'(gnt_o), 32'(v.g));
    chk("out_req_o", 32'(out_req_o), 32'(|v.req));
    chk("r_valid_o", 32'(r_valid_o), 32'(exp_rv));
    chk("starve_o", 32'(starve_o), WD ? 32'(v.st) : 32'd0);
    if (v.rst) begin
      #2 rst_ni = 1'b0;
      #1 chk("r_valid_o_in_reset", 32'(r_valid_o), 32'd0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      sb.delete();
      sb.push_back(4'h0);
    end else begin
      sb.push_back(v.clr ? 4'h0 : v.g);
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    // Reset state, checked while rst_ni is held low.
    rst_ni = 1'b0; clear_i = 1'b0; req_i = '0; out_gnt_i = 1'b0;
    out_r_valid_i = 1'b0; cfg_weight_i = '0;
    #3;
    n_vec++;
    chk("reset_sel_o", 32'(sel_o), 32'd0);
    chk("reset_gnt_o", 32'(gnt_o), 32'd0);
    chk("reset_r_valid_o", 32'(r_valid_o), 32'd0);
    chk("reset_starve_o", 32'(starve_o), 32'd0);
    chk("reset_out_req_o", 32'(out_req_o), 32'd0);
    req_i = 4'b1010;
    #1;
    chk("reset_out_req_busy", 32'(out_req_o), 32'd1);
    chk("reset_gnt_stalled", 32'(gnt_o), 32'd0);
    req_i = '0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    sb.push_back(4'h0);

    // Equal weights, all requesting: plain rotation 0,1,2,3,0.
    add(0,0,4'b1111,1,1,16'h1111,0,4'b0001,4'b0000);
    add(0,0,4'b1111,1,1,16'h1111,1,4'b0010,4'b0000);
    add(0,0,4'b1111,1,1,16'h1111,2,4'b0100,4'b0000);
    add(0,0,4'b1111,1,1,16'h1111,3,4'b1000,4'b0000);
    add(0,0,4'b1111,1,1,16'h1111,0,4'b0001,4'b0000);
    add(1,0,4'b0000,0,1,16'h1111,0,4'b0000,4'b0000);
    // Weight 3 on requester 0: 0,0,0,1 bursts; one cycle with r_valid masked.
    add(0,0,4'b0011,1,1,16'h1113,0,4'b0001,4'b0000);
    add(0,0,4'b0011,1,1,16'h1113,0,4'b0001,4'b0000);
    add(0,0,4'b0011,1,1,16'h1113,0,4'b0001,4'b0000);
    add(0,0,4'b0011,1,1,16'h1113,1,4'b0010,4'b0000);
    add(0,0,4'b0011,1,0,16'h1113,0,4'b0001,4'b0000);
    add(0,0,4'b0011,1,1,16'h1113,0,4'b0001,4'b0000);
    add(0,0,4'b0011,1,1,16'h1113,0,4'b0001,4'b0000);
    add(0,0,4'b0011,1,1,16'h1113,1,4'b0010,4'b0000);
    add(1,0,4'b0000,0,1,16'h1113,0,4'b0000,4'b0000);
    // Stall lock: winner 1 held even when requester 0 joins, then released.
    add(0,0,4'b0110,0,1,16'h1111,1,4'b0000,4'b0000);
    add(0,0,4'b0110,0,1,16'h1111,1,4'b0000,4'b0000);
    add(0,0,4'b0110,0,1,16'h1111,1,4'b0000,4'b0000);
    add(0,0,4'b0111,0,1,16'h1111,1,4'b0000,4'b0000);
    add(0,0,4'b0111,0,1,16'h1111,1,4'b0000,4'b0110);
    add(0,0,4'b0111,1,1,16'h1111,1,4'b0010,4'b0110);
    add(0,0,4'b0111,1,1,16'h1111,2,4'b0100,4'b0100);
    add(1,0,4'b0000,0,1,16'h1111,0,4'b0000,4'b0001);
    // Zero weights count as 1; requester 2 with weight 2, then requester 0 joins.
    add(0,0,4'b0100,1,1,16'h0200,2,4'b0100,4'b0000);
    add(0,0,4'b0100,1,1,16'h0200,2,4'b0100,4'b0000);
    add(0,0,4'b0100,1,1,16'h0200,2,4'b0100,4'b0000);
    add(0,0,4'b0101,1,1,16'h0200,2,4'b0100,4'b0000);
    add(0,0,4'b0101,1,1,16'h0200,0,4'b0001,4'b0000);
    add(0,0,4'b0101,1,1,16'h0200,2,4'b0100,4'b0000);
    add(1,0,4'b0000,0,1,16'h0200,0,4'b0000,4'b0000);
    // Reset during a handshake: pending r_valid dropped, credits and pointer restart.
    add(0,0,4'b0011,1,1,16'h1113,0,4'b0001,4'b0000);
    add(0,0,4'b0011,1,1,16'h1113,0,4'b0001,4'b0000);
    add(0,1,4'b0010,1,1,16'h1113,1,4'b0010,4'b0000);
    add(0,0,4'b0011,1,1,16'h1113,0,4'b0001,4'b0000);
    add(0,0,4'b0011,1,1,16'h1113,0,4'b0001,4'b0000);
    add(1,0,4'b0000,0,1,16'h1113,0,4'b0000,4'b0000);
    if (WD) begin
      // Heavy weight on requester 0 starves requester 1 until the watchdog fires.
      add(0,0,4'b0011,1,1,16'h111F,0,4'b0001,4'b0000);
      add(0,0,4'b0011,1,1,16'h111F,0,4'b0001,4'b0000);
      add(0,0,4'b0011,1,1,16'h111F,0,4'b0001,4'b0000);
      add(0,0,4'b0011,1,1,16'h111F,0,4'b0001,4'b0000);
      add(0,0,4'b0011,1,1,16'h111F,1,4'b0010,4'b0010);
      add(0,0,4'b0011,1,1,16'h111F,0,4'b0001,4'b0000);
      add(1,0,4'b0000,0,1,16'h111F,0,4'b0000,4'b0000);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
